dma_periph_endpoint: RTL and testbench
======================================

DMA_PERIPH_ENDPOINT -- requirements
Module: dma_periph_endpoint

Interface
REQ-001 Parameter DEPTH, 8, FIFO depth in bytes (power of 2, >=2).
REQ-002 Parameter DW, 8, data width.
REQ-003 CLK  input  1  single clock; all state changes on posedge.
REQ-004 RESET_N  input  1  synchronous, active-low reset.
REQ-005 ENABLE  input  1  channel enable from local logic.
REQ-006 MODE  input  2  01 = DMA write (device->memory, IOR_N strobe); 10 = DMA read (memory->device, IOW_N strobe); 00/11 = no requests.
REQ-007 DEMAND  input  1  1 = demand mode, 0 = single mode.
REQ-008 DREQ  output  1  DMA request to controller, active-high, registered.
REQ-009 DACK  input  1  DMA acknowledge, active-high.
REQ-010 IOR_N, IOW_N  input  1 each  controller I/O strobes, active-low.
REQ-011 EOP_N  input  1  end of process from controller, active-low.
REQ-012 DB_IN  input  DW  bus data in; DB_OUT output DW bus data out; DB_OE output 1 bus drive enable.
REQ-013 PUSH_VALID input 1, PUSH_DATA input DW, PUSH_READY output 1: local write port into FIFO.
REQ-014 POP_VALID output 1, POP_DATA output DW, POP_READY input 1: local read port from FIFO head.
REQ-015 FIFO_COUNT  output  log2(DEPTH)+1  bytes held; DONE  output  1  sticky terminal-count flag.

Function
REQ-016 FSM states: IDLE, REQ, XFER, RECOVER, TERM; one state per cycle minimum.
REQ-017 "Ready" SHALL mean ENABLE=1 and (MODE=01 and FIFO_COUNT>0, or MODE=10 and FIFO_COUNT<DEPTH).
REQ-018 IDLE -> REQ when ready; DREQ SHALL be 1 exactly while in REQ or XFER.
REQ-019 REQ -> IDLE when ENABLE=0; REQ -> XFER when DACK=1 and the mode strobe (IOR_N for 01, IOW_N for 10) is sampled low.
REQ-020 Strobes without DACK=1, non-matching strobes, or IOR_N and IOW_N both low SHALL be ignored.
REQ-021 MODE 01 in XFER: DB_OE=1 and DB_OUT=FIFO head while IOR_N is low; DB_OE SHALL be 0 in all other states/modes.
REQ-022 MODE 10 in XFER: DB_IN SHALL be captured every cycle IOW_N is sampled low.
REQ-023 XFER ends on the first cycle the strobe is sampled high: MODE 01 pops head, MODE 10 pushes last captured byte; -> RECOVER.
REQ-024 DACK sampled 0 in XFER before strobe release SHALL abort: no FIFO change, -> IDLE.
REQ-025 EOP_N sampled low in REQ, XFER or RECOVER SHALL set an internal eop latch; an XFER in progress still completes.
REQ-026 RECOVER (1 cycle): eop latch set -> TERM; else DEMAND=1 and ready -> REQ; else -> IDLE (single mode: DREQ low >=1 cycle between transfers).
REQ-027 TERM: DONE=1, DREQ=0; stays until ENABLE=0, then -> IDLE clearing DONE and eop latch.
REQ-028 ENABLE=0 in XFER SHALL not abort; the transfer completes, then RECOVER -> IDLE.
REQ-029 PUSH_READY = (FIFO_COUNT<DEPTH); POP_VALID = (FIFO_COUNT>0); POP_DATA = FIFO head; both combinational from registered state.
REQ-030 A local push accepted when PUSH_VALID&&PUSH_READY; a local pop when POP_VALID&&POP_READY.
REQ-031 DMA-side and local-side FIFO operations in the same cycle SHALL both take effect; simultaneous push and pop leave FIFO_COUNT unchanged.
REQ-032 FIFO pointers SHALL wrap modulo DEPTH; FIFO_COUNT SHALL never exceed DEPTH or underflow.
REQ-033 MODE and DEMAND SHALL be sampled only in IDLE; changes while not IDLE take effect after return to IDLE.

Reset
REQ-034 RESET_N=0 at posedge SHALL force state IDLE, DREQ=0, DB_OE=0, DONE=0, eop latch 0, FIFO pointers and FIFO_COUNT 0 (PUSH_READY=1, POP_VALID=0), regardless of state, including mid-XFER.
REQ-035 DB_OUT SHALL reset to 0; FIFO storage contents need not reset.

Verification
REQ-036 MODE=01, single, push 0xA5,0x3C; DACK=1, IOR_N low 2 cycles -> DB_OE=1, DB_OUT=0xA5, after release FIFO_COUNT=1, DREQ low 1 cycle, then reasserts.
REQ-037 MODE=10, demand, empty FIFO; DB_IN=0x5A during IOW_N low with DACK, repeat 8 times -> FIFO_COUNT=8, DREQ drops after 8th, POP_DATA=0x5A.
REQ-038 MODE=01, FIFO 3 bytes, EOP_N low during 2nd XFER -> transfer completes, FIFO_COUNT=1, DONE=1, DREQ=0 until ENABLE=0 then DONE=0.
REQ-039 MODE=10, IOW_N low with DACK=0, then DACK drops mid-XFER -> no FIFO change, state IDLE, DREQ reasserts next request.
REQ-040 MODE=10, FIFO_COUNT=7: DMA push and local pop same cycle -> FIFO_COUNT stays 7; RESET_N low mid-XFER -> DREQ=0, FIFO_COUNT=0 next cycle.

Source files
------------

// File: rtl/dma_periph_endpoint_if.sv
// DMA controller bus seen by a peripheral endpoint.
// Master is the controller side, slave is the endpoint.
interface dma_periph_endpoint_if #(
    parameter int DW = 8
);
    logic          dreq;
    logic          dack;
    logic          ior_n;
    logic          iow_n;
    logic          eop_n;
    logic [DW-1:0] db_in;
    logic [DW-1:0] db_out;
    logic          db_oe;

    modport master (
        input  dreq, db_out, db_oe,
        output dack, ior_n, iow_n, eop_n, db_in
    );

    modport slave (
        output dreq, db_out, db_oe,
        input  dack, ior_n, iow_n, eop_n, db_in
    );
endinterface

// File: rtl/dma_periph_endpoint.sv
// Peripheral-side DMA endpoint: request FSM plus a byte FIFO
// shared between the DMA bus and a local push/pop port.
module dma_periph_endpoint #(
    parameter  int DEPTH = 8,
    parameter  int DW    = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic                  demand,
    dma_periph_endpoint_if.slave  bus,
    input  logic                  push_valid,
    input  logic [DW-1:0]         push_data,
    output logic                  push_ready,
    output logic                  pop_valid,
    output logic [DW-1:0]         pop_data,
    input  logic                  pop_ready,
    output logic [CW-1:0]         fifo_count,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, REQ, XFER, RECOVER, TERM} state_t;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [1:0] M_WR = 2'b01;
    localparam logic [1:0] M_RD = 2'b10;

    state_t        state, state_n;
    logic [1:0]    mode_q, cur_mode;
    logic          demand_q, eop_q, dreq_q, done_q;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, room;
    logic [DW-1:0] cap;
    logic          ready, strobe_go, strobe_held, eop_hit;
    logic          d_push, d_pop, d_push_ok, d_pop_ok, l_push, l_pop;
    logic [1:0]    n_push, n_pop;
    logic          oe;
    logic [DW-1:0] dout;

    // mode is only honoured when sampled in IDLE
    assign cur_mode = (state == IDLE) ? mode : mode_q;
    assign ready = enable &&
                   ((cur_mode == M_WR && count != '0) ||
                    (cur_mode == M_RD && count < FULL));

    // a strobe counts only if it is the matching one and the other is high
    assign strobe_go = (mode_q == M_WR) ? (!bus.ior_n && bus.iow_n) :
                       (mode_q == M_RD) ? (!bus.iow_n && bus.ior_n) : 1'b0;
    assign strobe_held = (mode_q == M_WR) ? !bus.ior_n : !bus.iow_n;
    assign eop_hit = eop_q || !bus.eop_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            dreq_q   <= 1'b0;
            done_q   <= 1'b0;
            eop_q    <= 1'b0;
            mode_q   <= 2'b00;
            demand_q <= 1'b0;
        end else begin
            state  <= state_n;
            dreq_q <= (state_n == REQ) || (state_n == XFER);
            done_q <= (state_n == TERM);
            if (state == IDLE) begin
                mode_q   <= mode;
                demand_q <= demand;
            end
            if (state == IDLE || (state == TERM && !enable))
                eop_q <= 1'b0;
            else if (!bus.eop_n &&
                     (state == REQ || state == XFER || state == RECOVER))
                eop_q <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (ready) state_n = REQ;
            REQ: begin
                if (!enable)                      state_n = IDLE;
                else if (bus.dack && strobe_go)   state_n = XFER;
            end
            XFER: begin
                if (!strobe_held)  state_n = RECOVER;
                else if (!bus.dack) state_n = IDLE;
            end
            RECOVER: begin
                if (eop_hit)                state_n = TERM;
                else if (demand_q && ready) state_n = REQ;
                else                        state_n = IDLE;
            end
            TERM:    if (!enable) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        oe   = (state == XFER) && (mode_q == M_WR) && !bus.ior_n;
        dout = oe ? mem[rptr] : '0;
    end

    assign bus.dreq   = dreq_q;
    assign bus.db_oe  = oe;
    assign bus.db_out = dout;
    assign done       = done_q;

    assign push_ready = (count < FULL);
    assign pop_valid  = (count != '0);
    assign pop_data   = mem[rptr];
    assign fifo_count = count;

    assign d_push = (state == XFER) && (mode_q == M_RD) && bus.iow_n;
    assign d_pop  = (state == XFER) && (mode_q == M_WR) && bus.ior_n;
    assign l_push = push_valid && push_ready;
    assign l_pop  = pop_valid && pop_ready;

    // both sides popping the last byte consume it only once
    always_comb begin
        d_pop_ok = d_pop && (count != '0);
        if (d_pop_ok && l_pop)
            n_pop = (count >= CW'(2)) ? 2'd2 : 2'd1;
        else
            n_pop = {1'b0, d_pop_ok || l_pop};
        room      = count + CW'(l_push) - CW'(n_pop);
        d_push_ok = d_push && (room < FULL);
        n_push    = {1'b0, d_push_ok} + {1'b0, l_push};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            cap   <= '0;
        end else begin
            wptr  <= wptr + AW'(n_push);
            rptr  <= rptr + AW'(n_pop);
            count <= count + CW'(n_push) - CW'(n_pop);
            if (mode_q == M_RD && !bus.iow_n &&
                (state == XFER || (state == REQ && state_n == XFER)))
                cap <= bus.db_in;
        end
    end

    always_ff @(posedge clk) begin
        if (d_push_ok)
            mem[wptr] <= cap;
        if (l_push)
            mem[wptr + AW'(d_push_ok)] <= push_data;
    end
endmodule

// File: tb/tb_dma_periph_endpoint.sv
// Directed bench for dma_periph_endpoint.
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_dma_periph_endpoint;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [1:0] mode;
    logic       demand;
    logic       push_valid;
    logic [7:0] push_data;
    logic       push_ready;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic       pop_ready;
    logic [3:0] fifo_count;
    logic       done;

    int total = 0;
    int bad   = 0;

    dma_periph_endpoint_if #(.DW(8)) bus ();

    dma_periph_endpoint #(.DEPTH(8), .DW(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .mode       (mode),
        .demand     (demand),
        .bus        (bus),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_ready  (pop_ready),
        .fifo_count (fifo_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_dreq(input string tag);
        for (int k = 0; k < 6; k++) begin
            if (bus.dreq === 1'b1) break;
            tick();
        end
        chk(tag, bus.dreq, 1);
    endtask

    task automatic push(input logic [7:0] d);
        push_valid = 1'b1;
        push_data  = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        pop_ready = 1'b1;
        repeat (n) tick();
        pop_ready = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        mode       = 2'b00;
        demand     = 1'b0;
        push_valid = 1'b0;
        push_data  = 8'h00;
        pop_ready  = 1'b0;
        bus.dack   = 1'b0;
        bus.ior_n  = 1'b1;
        bus.iow_n  = 1'b1;
        bus.eop_n  = 1'b1;
        bus.db_in  = 8'h00;
        tick();
        tick();
        chk("rst_dreq", bus.dreq, 0);
        chk("rst_oe", bus.db_oe, 0);
        chk("rst_dout", bus.db_out, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", fifo_count, 0);
        chk("rst_pready", push_ready, 1);
        chk("rst_pvalid", pop_valid, 0);
        reset_n = 1'b1;
        tick();

        // device->memory, single mode
        mode = 2'b01;
        push(8'hA5);
        push(8'h3C);
        chk("t1_cnt2", fifo_count, 2);
        chk("t1_head", pop_data, 8'hA5);
        enable = 1'b1;
        tick();
        chk("t1_dreq", bus.dreq, 1);
        bus.dack  = 1'b1;
        bus.ior_n = 1'b0;
        tick();
        chk("t1_oe", bus.db_oe, 1);
        chk("t1_dout", bus.db_out, 8'hA5);
        tick();
        chk("t1_oe2", bus.db_oe, 1);
        bus.ior_n = 1'b1;
        tick();
        bus.dack = 1'b0;
        chk("t1_cnt1", fifo_count, 1);
        chk("t1_dreq_lo", bus.dreq, 0);
        chk("t1_oe_off", bus.db_oe, 0);
        chk("t1_head2", pop_data, 8'h3C);
        wait_dreq("t1_reassert");
        enable = 1'b0;
        tick();
        drain(1);
        chk("t1_empty", fifo_count, 0);

        // memory->device, demand mode, fill to full
        mode   = 2'b10;
        demand = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_dreq("t2_dreq");
            bus.dack  = 1'b1;
            bus.iow_n = 1'b0;
            bus.db_in = 8'h11;
            tick();
            chk("t2_oe", bus.db_oe, 0);
            bus.db_in = 8'h5A;
            tick();
            bus.iow_n = 1'b1;
            tick();
            bus.dack = 1'b0;
            chk("t2_dreq_lo", bus.dreq, 0);
        end
        chk("t2_cnt8", fifo_count, 8);
        tick();
        chk("t2_dreq_full", bus.dreq, 0);
        chk("t2_head", pop_data, 8'h5A);
        chk("t2_pready", push_ready, 0);
        enable = 1'b0;
        tick();
        drain(8);
        chk("t2_empty", fifo_count, 0);

        // end of process during second transfer
        mode   = 2'b01;
        demand = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        enable = 1'b1;
        wait_dreq("t3_dreq1");
        bus.dack  = 1'b1;
        bus.ior_n = 1'b0;
        tick();
        chk("t3_dout1", bus.db_out, 8'h11);
        bus.ior_n = 1'b1;
        tick();
        bus.dack = 1'b0;
        chk("t3_cnt2", fifo_count, 2);
        wait_dreq("t3_dreq2");
        bus.dack  = 1'b1;
        bus.ior_n = 1'b0;
        tick();
        chk("t3_dout2", bus.db_out, 8'h22);
        bus.eop_n = 1'b0;
        tick();
        bus.eop_n = 1'b1;
        bus.ior_n = 1'b1;
        tick();
        bus.dack = 1'b0;
        chk("t3_cnt1", fifo_count, 1);
        tick();
        chk("t3_done", done, 1);
        chk("t3_dreq_term", bus.dreq, 0);
        tick();
        chk("t3_done_hold", done, 1);
        chk("t3_dreq_hold", bus.dreq, 0);
        enable = 1'b0;
        tick();
        chk("t3_done_clr", done, 0);
        chk("t3_head", pop_data, 8'h33);
        drain(1);

        // ignored strobes and DACK abort
        mode   = 2'b10;
        demand = 1'b0;
        enable = 1'b1;
        wait_dreq("t4_dreq");
        bus.iow_n = 1'b0;
        tick();
        tick();
        chk("t4_nodack", bus.dreq, 1);
        bus.iow_n = 1'b1;
        bus.dack  = 1'b1;
        bus.ior_n = 1'b0;
        tick();
        bus.iow_n = 1'b0;
        tick();
        bus.ior_n = 1'b1;
        bus.iow_n = 1'b1;
        tick();
        chk("t4_ign_cnt", fifo_count, 0);
        chk("t4_ign_dreq", bus.dreq, 1);
        bus.iow_n = 1'b0;
        bus.db_in = 8'h77;
        tick();
        bus.dack = 1'b0;
        tick();
        chk("t4_abort_dreq", bus.dreq, 0);
        chk("t4_abort_cnt", fifo_count, 0);
        bus.iow_n = 1'b1;
        tick();
        chk("t4_rereq", bus.dreq, 1);
        enable = 1'b0;
        tick();

        // simultaneous DMA push and local pop, then reset mid-transfer
        for (int i = 0; i < 7; i++) push(8'h10 + 8'(i));
        chk("t5_cnt7", fifo_count, 7);
        enable = 1'b1;
        wait_dreq("t5_dreq");
        bus.dack  = 1'b1;
        bus.iow_n = 1'b0;
        bus.db_in = 8'hEE;
        tick();
        bus.iow_n = 1'b1;
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        bus.dack  = 1'b0;
        chk("t5_cnt_same", fifo_count, 7);
        chk("t5_head", pop_data, 8'h11);
        wait_dreq("t5_dreq2");
        bus.dack  = 1'b1;
        bus.iow_n = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        chk("t5_rst_dreq", bus.dreq, 0);
        chk("t5_rst_cnt", fifo_count, 0);
        chk("t5_rst_pready", push_ready, 1);
        chk("t5_rst_pvalid", pop_valid, 0);
        chk("t5_rst_done", done, 0);
        reset_n   = 1'b1;
        bus.dack  = 1'b0;
        bus.iow_n = 1'b1;
        enable    = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
